// File: rtl/psram_pkg.sv
// Shared definitions for the PSRAM write path: bus widths, the sequencer FSM
// encoding, the device page size and the controller command codes.
package psram_pkg;

  localparam int ADDR_W = 24;
  localparam int DATA_W = 8;

  // One FIFO entry carries the byte address in the upper bits and the data byte below.
  localparam int ENTRY_W = ADDR_W + DATA_W;

  // Bursts are not allowed to run across a PSRAM page.
  localparam int PSRAM_PAGE_BYTES = 1024;

  // Write sequencer FSM encoding.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_STREAM = 2'd2,
    ST_CLOSE  = 2'd3
  } seq_state_t;

  // Controller command opcodes, shared so controller and sequencer agree.
  localparam logic [7:0] CMD_WRITE       = 8'h02;
  localparam logic [7:0] CMD_READ        = 8'h03;
  localparam logic [7:0] CMD_FAST_READ   = 8'h0B;
  localparam logic [7:0] CMD_QUAD_WRITE  = 8'h38;
  localparam logic [7:0] CMD_ENTER_QUAD  = 8'h35;
  localparam logic [7:0] CMD_RESET_EN    = 8'h66;
  localparam logic [7:0] CMD_RESET       = 8'h99;

endpackage

// File: rtl/psram_write_fifo.sv
// Synchronous show-ahead FIFO of {address, data} entries. The head entry is
// always visible on head; full, empty and level are registered so downstream
// logic sees occupancy as it stood at the start of the cycle.
module psram_write_fifo
  import psram_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic               push_ok;
  logic               pop_ok;
  logic [LW-1:0]      level_next;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Occupancy after this edge; a simultaneous push and pop cancel out.
  always_comb begin
    level_next = level;
    if (push_ok && !pop_ok) begin
      level_next = level + LW'(1);
    end else if (pop_ok && !push_ok) begin
      level_next = level - LW'(1);
    end
  end

  // Storage array; contents need no reset because pointers define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      level <= level_next;
      full  <= (level_next == LW'(DEPTH));
      empty <= (level_next == '0);
    end
  end

endmodule

// File: rtl/psram_write_sequencer.sv
// Buffers host byte writes and replays them to the PSRAM controller, merging
// runs of consecutive addresses into one burst. A burst opens with a
// set_address strobe and continues with one write_data strobe per controller
// request until the run breaks, the page ends, the length cap is hit or
// flush is raised.
module psram_write_sequencer
  import psram_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int MAX_BURST  = 32,
  parameter int PAGE_BYTES = PSRAM_PAGE_BYTES,
  parameter int CE_GAP     = 2
) (
  input  logic                          sysclk,
  input  logic                          reset,
  input  logic                          wr_valid,
  output logic                          wr_ready,
  input  logic [ADDR_W-1:0]             wr_address,
  input  logic [DATA_W-1:0]             wr_data,
  input  logic                          flush,
  output logic                          psram_enable,
  output logic                          psram_set_address,
  output logic                          psram_write_data,
  output logic [ADDR_W-1:0]             psram_address,
  output logic [DATA_W-1:0]             psram_data,
  input  logic                          psram_next_byte_needed,
  output logic                          idle,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   burst_count
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(MAX_BURST + 1);
  localparam int GW = $clog2(CE_GAP + 1);
  localparam int PW = $clog2(PAGE_BYTES);
  localparam logic [GW-1:0] GAP_LAST = GW'(CE_GAP - 1);

  seq_state_t          state;
  logic [ENTRY_W-1:0]  head;
  logic [ADDR_W-1:0]   head_addr;
  logic [DATA_W-1:0]   head_data;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                pop;
  logic [LW-1:0]       level_next;
  logic [ADDR_W-1:0]   last_addr;
  logic [ADDR_W-1:0]   next_addr;
  logic [CW-1:0]       byte_count;
  logic [GW-1:0]       gap_count;
  logic                eligible;
  logic                next_is_idle;

  assign head_addr = head[ENTRY_W-1:DATA_W];
  assign head_data = head[DATA_W-1:0];
  assign wr_ready  = !fifo_full;
  assign push      = wr_valid && wr_ready;
  assign next_addr = last_addr + ADDR_W'(1);

  psram_write_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (sysclk),
    .reset     (reset),
    .push      (push),
    .push_data ({wr_address, wr_data}),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  // Decide whether the head may extend the open burst, and when to pop it.
  always_comb begin
    eligible = !fifo_empty
            && (head_addr == next_addr)
            && (next_addr[PW-1:0] != '0)
            && (byte_count < CW'(MAX_BURST))
            && !flush;
    pop = (state == ST_START)
       || ((state == ST_STREAM) && psram_next_byte_needed && eligible);
    level_next = fifo_level;
    if (push && !pop) begin
      level_next = fifo_level + LW'(1);
    end else if (pop && !push) begin
      level_next = fifo_level - LW'(1);
    end
    next_is_idle = ((state == ST_IDLE) && fifo_empty)
                || ((state == ST_CLOSE) && (gap_count == GAP_LAST));
  end

  // Burst FSM with all controller-facing outputs registered.
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state             <= ST_IDLE;
      psram_enable      <= 1'b0;
      psram_set_address <= 1'b0;
      psram_write_data  <= 1'b0;
      psram_address     <= '0;
      psram_data        <= '0;
      burst_count       <= '0;
      last_addr         <= '0;
      byte_count        <= '0;
      gap_count         <= '0;
      idle              <= 1'b1;
    end else begin
      psram_set_address <= 1'b0;
      psram_write_data  <= 1'b0;
      idle              <= next_is_idle && (level_next == '0);
      case (state)
        ST_IDLE: begin
          if (!fifo_empty) begin
            state <= ST_START;
          end
        end
        ST_START: begin
          psram_enable      <= 1'b1;
          psram_set_address <= 1'b1;
          psram_address     <= head_addr;
          psram_data        <= head_data;
          last_addr         <= head_addr;
          byte_count        <= CW'(1);
          state             <= ST_STREAM;
        end
        ST_STREAM: begin
          if (psram_next_byte_needed) begin
            if (eligible) begin
              psram_write_data <= 1'b1;
              psram_data       <= head_data;
              last_addr        <= next_addr;
              byte_count       <= byte_count + CW'(1);
            end else begin
              psram_enable <= 1'b0;
              burst_count  <= burst_count + 16'd1;
              gap_count    <= '0;
              state        <= ST_CLOSE;
            end
          end
        end
        ST_CLOSE: begin
          if (gap_count == GAP_LAST) begin
            state <= ST_IDLE;
          end else begin
            gap_count <= gap_count + GW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
